// File: rtl/fft_reorder_pkg.sv
// Shared types and bin-mapping helpers for the FFT output reorder stage.
package fft_reorder_pkg;

    localparam int unsigned LANES         = 4;
    localparam int unsigned KW            = 16;
    localparam int unsigned NBITS_OUT_DEF = 21;

    typedef logic [2*NBITS_OUT_DEF-1:0] sample_t;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    // Reverse the low log2n bits of k.
    function automatic logic [KW-1:0] bitrev(input logic [KW-1:0] k, input int unsigned log2n);
        logic [KW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            if (i < log2n) begin
                r[4'(log2n - 1 - i)] = k[4'(i)];
            end
        end
        return r;
    endfunction

    // Skewed bank: bin LSBs plus bin MSBs, mod 4.
    function automatic logic [1:0] bank_of(input logic [KW-1:0] k, input int unsigned log2n);
        return 2'(k[1:0] + k[4'(log2n - 1) -: 2]);
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Simple dual-port RAM with a registered read port; contents are not reset.
module fft_reorder_bank
    import fft_reorder_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 42
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_output_reorder.sv
// Bit-reversed to natural order reorder buffer, 4 bins/beat, ping-pong 4-bank RAM.
// Optional FFT_REORDER_SOF_CHECK_EN adds in_sof framing check with sticky sof_err.
module fft_output_reorder
    import fft_reorder_pkg::*;
#(
    parameter int unsigned N         = 128,
    parameter int unsigned NBITS_out = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [2*NBITS_out-1:0] in0_up,
    input  logic [2*NBITS_out-1:0] in0_down,
    input  logic [2*NBITS_out-1:0] in1_up,
    input  logic [2*NBITS_out-1:0] in1_down,
`ifdef FFT_REORDER_SOF_CHECK_EN
    input  logic                   in_sof,
    output logic                   sof_err,
`endif
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [2*NBITS_out-1:0] out0,
    output logic [2*NBITS_out-1:0] out1,
    output logic [2*NBITS_out-1:0] out2,
    output logic [2*NBITS_out-1:0] out3
);

    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned B     = N / 4;
    localparam int unsigned CW    = LOG2N - 2;
    localparam int unsigned AW    = LOG2N - 1;
    localparam int unsigned SW    = 2 * NBITS_out;

    rd_state_t state_q, state_d;
    logic [CW-1:0] wc_q, wc_d, c_q, c_d, wc_eff;
    logic          wh_q, wh_d, rh_q, rh_d;
    logic          frame_done, sof_bad;

    logic [SW-1:0] lane_in   [LANES];
    logic [KW-1:0] lane_k    [LANES];
    logic [1:0]    lane_bank [LANES];
    logic          bank_we    [LANES];
    logic [AW-1:0] bank_waddr [LANES];
    logic [SW-1:0] bank_wdata [LANES];
    logic [SW-1:0] bank_rdata [LANES];

    logic          rd_valid_q, rd_sof_q, rd_eof_q;
    logic [1:0]    rd_rot_q;
    logic [SW-1:0] out_d [LANES];
    logic [SW-1:0] out_q [LANES];
    logic          out_valid_q, out_sof_q, out_eof_q;

    assign lane_in[0] = in0_up;
    assign lane_in[1] = in0_down;
    assign lane_in[2] = in1_up;
    assign lane_in[3] = in1_down;

`ifdef FFT_REORDER_SOF_CHECK_EN
    logic sof_err_q;
    // A misplaced in_sof restarts the frame at this beat.
    assign sof_bad = in_valid & in_sof & (wc_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sof_err_q <= 1'b0;
        end else if (sof_bad) begin
            sof_err_q <= 1'b1;
        end
    end
    assign sof_err = sof_err_q;
`else
    assign sof_bad = 1'b0;
`endif

    assign wc_eff     = sof_bad ? '0 : wc_q;
    assign frame_done = in_valid && (wc_eff == CW'(B - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            rh_q    <= 1'b0;
            wc_q    <= '0;
            wh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            rh_q    <= rh_d;
            wc_q    <= wc_d;
            wh_q    <= wh_d;
        end
    end

    // Write counter/half and read FSM; a completed frame always (re)starts a read.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        rh_d    = rh_q;
        wc_d    = wc_q;
        wh_d    = wh_q;
        if (in_valid) begin
            wc_d = wc_eff + CW'(1);
            if (frame_done) begin
                wh_d = ~wh_q;
            end
        end
        if (frame_done) begin
            state_d = READ;
            c_d     = '0;
            rh_d    = wh_q;
        end else begin
            case (state_q)
                READ: begin
                    if (c_q == CW'(B - 1)) begin
                        state_d = IDLE;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            lane_k[l]    = bitrev(KW'({wc_eff, 2'(l)}), LOG2N);
            lane_bank[l] = bank_of(lane_k[l], LOG2N);
        end
    end

    // Write crossbar: the skew puts each lane of a beat in a distinct bank.
    always_comb begin
        for (int b = 0; b < int'(LANES); b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = '0;
            bank_wdata[b] = '0;
            for (int l = 0; l < int'(LANES); l++) begin
                if (lane_bank[l] == 2'(b)) begin
                    bank_we[b]    = in_valid;
                    bank_waddr[b] = {wh_q, lane_k[l][LOG2N-1:2]};
                    bank_wdata[b] = lane_in[l];
                end
            end
        end
    end

    for (genvar b = 0; b < int'(LANES); b++) begin : g_bank
        fft_reorder_bank #(
            .DEPTH (N / 2),
            .AW    (AW),
            .DW    (SW)
        ) u_bank (
            .clk     (clk),
            .we_i    (bank_we[b]),
            .waddr_i (bank_waddr[b]),
            .wdata_i (bank_wdata[b]),
            .raddr_i ({rh_q, c_q}),
            .rdata_o (bank_rdata[b])
        );
    end

    // Sideband aligned with the registered bank read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_sof_q   <= 1'b0;
            rd_eof_q   <= 1'b0;
            rd_rot_q   <= '0;
        end else begin
            rd_valid_q <= (state_q == READ);
            rd_sof_q   <= (state_q == READ) && (c_q == '0);
            rd_eof_q   <= (state_q == READ) && (c_q == CW'(B - 1));
            rd_rot_q   <= c_q[CW-1 -: 2];
        end
    end

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            out_d[l] = rd_valid_q ? bank_rdata[2'(2'(l) + rd_rot_q)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                out_q[l] <= '0;
            end
        end else begin
            out_valid_q <= rd_valid_q;
            out_sof_q   <= rd_sof_q;
            out_eof_q   <= rd_eof_q;
            for (int l = 0; l < int'(LANES); l++) begin
                out_q[l] <= out_d[l];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder (N=128); covers FFT_REORDER_SOF_CHECK_EN when defined.
module tb_fft_output_reorder;
    import fft_reorder_pkg::*;

    localparam int N     = 128;
    localparam int B     = 32;
    localparam int LOG2N = 7;
    localparam int NB    = 21;
    localparam int SW    = 42;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in0_up = '0, in0_down = '0, in1_up = '0, in1_down = '0;
    logic          out_valid, out_sof, out_eof;
    logic [SW-1:0] out0, out1, out2, out3;
`ifdef FFT_REORDER_SOF_CHECK_EN
    logic          in_sof = 1'b0;
    logic          sof_err;
`endif

    fft_output_reorder #(.N(N), .NBITS_out(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in0_up    (in0_up),
        .in0_down  (in0_down),
        .in1_up    (in1_up),
        .in1_down  (in1_down),
`ifdef FFT_REORDER_SOF_CHECK_EN
        .in_sof    (in_sof),
        .sof_err   (sof_err),
`endif
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][SW-1:0] d;
        logic               sof;
        logic               eof;
    } exp_t;

    exp_t    exp_q[$];
    exp_t    mon_e;
    bit      exp_valid [8192];
    sample_t frame_bins [N];
    int      cyc = 0;
    int      pass_cnt = 0;
    int      fail_cnt = 0;
    int      total_cnt = 0;
    bit      mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int tb_bitrev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (k[i]) r = r | (1 << (LOG2N - 1 - i));
        end
        return r;
    endfunction

    task automatic fill_ramp(input int off);
        for (int k = 0; k < N; k++) begin
            frame_bins[k] = {NB'(k + off), NB'(-(k + off))};
        end
    endtask

    task automatic fill_extreme();
        for (int k = 0; k < N; k++) frame_bins[k] = '0;
        frame_bins[5] = {21'h100000, 21'h0FFFFF};
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int w, input logic sof);
        in0_up   = frame_bins[tb_bitrev(4 * w + 0)];
        in0_down = frame_bins[tb_bitrev(4 * w + 1)];
        in1_up   = frame_bins[tb_bitrev(4 * w + 2)];
        in1_down = frame_bins[tb_bitrev(4 * w + 3)];
        in_valid = 1'b1;
`ifdef FFT_REORDER_SOF_CHECK_EN
        in_sof   = sof;
`endif
        if (sof) begin end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef FFT_REORDER_SOF_CHECK_EN
        in_sof   = 1'b0;
`endif
    endtask

    // Expected frame starts two edges after the edge that accepted the last beat.
    task automatic schedule_frame(input int e);
        exp_t x;
        for (int c = 0; c < B; c++) begin
            exp_valid[e + 2 + c] = 1'b1;
            for (int l = 0; l < 4; l++) x.d[l] = frame_bins[4 * c + l];
            x.sof = (c == 0);
            x.eof = (c == B - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic send_frame(input int first_w, input int gap);
        for (int w = first_w; w < B; w++) begin
            drive_beat(w, w == 0);
            if (w == B - 1) schedule_frame(cyc);
            else repeat (gap) idle_cycle();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle_cycle();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) idle_cycle();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_valid[cyc]));
            if (out_valid && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("out0", 64'(out0), 64'(mon_e.d[0]));
                check("out1", 64'(out1), 64'(mon_e.d[1]));
                check("out2", 64'(out2), 64'(mon_e.d[2]));
                check("out3", 64'(out3), 64'(mon_e.d[3]));
                check("out_sof", 64'(out_sof), 64'(mon_e.sof));
                check("out_eof", 64'(out_eof), 64'(mon_e.eof));
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sof", 64'(out_sof), 64'd0);
        check("rst_out_eof", 64'(out_eof), 64'd0);
        check("rst_out0", 64'(out0), 64'd0);
        check("rst_out3", 64'(out3), 64'd0);
`ifdef FFT_REORDER_SOF_CHECK_EN
        check("rst_sof_err", 64'(sof_err), 64'd0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;
        idle_cycle();

        // single ramp frame
        fill_ramp(0);
        send_frame(0, 0);
        drain();

        // three back-to-back frames
        fill_ramp(0);
        send_frame(0, 0);
        fill_ramp(1000);
        send_frame(0, 0);
        fill_ramp(2000);
        send_frame(0, 0);
        drain();

        // in_valid every other cycle
        fill_ramp(0);
        send_frame(0, 1);
        drain();

        // reset in the middle of a frame, then a full frame
        fill_ramp(500);
        for (int w = 0; w < 15; w++) drive_beat(w, w == 0);
        rst = 1'b1;
        idle_cycle();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out1", 64'(out1), 64'd0);
        rst = 1'b0;
        fill_ramp(0);
        send_frame(0, 0);
        drain();

        // extreme values on bin 5 only
        fill_extreme();
        send_frame(0, 0);
        drain();

`ifdef FFT_REORDER_SOF_CHECK_EN
        // misplaced in_sof at beat 10 drops the partial frame
        fill_ramp(300);
        for (int w = 0; w < 10; w++) drive_beat(w, w == 0);
        check("sof_err_before", 64'(sof_err), 64'd0);
        fill_ramp(0);
        drive_beat(0, 1'b1);
        check("sof_err_set", 64'(sof_err), 64'd1);
        send_frame(1, 0);
        drain();
        check("sof_err_sticky", 64'(sof_err), 64'd1);
        rst = 1'b1;
        idle_cycle();
        check("sof_err_cleared", 64'(sof_err), 64'd0);
        rst = 1'b0;
        idle_cycle();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
